ex_stage_mdu: RTL and testbench
===============================

# ex_stage_mdu

Parametrised execute stage with a built-in multi-cycle multiply/divide unit (MDU) and HI/LO registers. It sits between the ID/EX and EX/MEM boundaries and registers its own EX/MEM outputs. ALU operations complete in one cycle. Unsigned multiply and divide iterate one bit per cycle and stall the upstream pipeline through `Out_Stall`. A valid bit and a flush input support bubbles and branch squash.

## Interface
- `WIDTH`, default 32: datapath width; also the MDU iteration count.
- `REG_BITS`, default 5: register-specifier width.

- `Clk`  in  1  clock; all state changes on the rising edge.
- `Rst_n`  in  1  synchronous active-low reset.
- `In_Valid`  in  1  ID/EX holds a real instruction.
- `In_DataA`  in  WIDTH  rs operand.
- `In_DataB`  in  WIDTH  rt operand; also store data.
- `In_SE`  in  WIDTH  sign-extended immediate.
- `In_Rt`  in  REG_BITS  rt specifier.
- `In_Rd`  in  REG_BITS  rd specifier.
- `In_EXControl`  in  4  [3] RegDst, [2:1] ALUOp, [0] ALUSrc.
- `In_MEMControl`  in  2  passed through.
- `In_WBControl`  in  2  passed through.
- `In_Funct`  in  6  R-type function field.
- `In_Flush`  in  1  squash the current instruction.
- `Out_Stall`  out  1  combinational; upstream holds ID/EX while it is high.
- `Out_Valid`  out  1  EX/MEM entry is valid.
- `Out_Result`  out  WIDTH  ALU or HI/LO result.
- `Out_Data`  out  WIDTH  registered `In_DataB`.
- `Out_Rd`  out  REG_BITS  destination register: `In_Rd` if RegDst, else `In_Rt`.
- `Out_MEMControl`  out  2  registered; forced to 0 for a bubble.
- `Out_WBControl`  out  2  registered; forced to 0 for a bubble.

## Operation
- **Operand B:** ALUSrc ? `In_SE` : `In_DataB`.
- **ALUOp decode:**
  - 00: add.
  - 01: sub.
  - 11: or.
  - 10: decode by `In_Funct`:
    - 100000 add; 100010 sub; 100100 and; 100101 or.
    - 101010 slt, signed, result 1 or 0.
    - 010000 mfhi; 010010 mflo.
    - 011001 multu; 011011 divu.
    - Any other funct: result 0.
- **Arithmetic:** modulo 2^WIDTH, no overflow trap.
- **MDU FSM states:** IDLE, BUSY, DONE.
  - IDLE: a valid multu/divu with no flush latches the operands, clears the counter and moves to BUSY.
  - BUSY: one step per cycle.
    - multu: shift-add on a 2·WIDTH accumulator.
    - divu: restoring divide, one quotient bit per cycle.
    - After WIDTH steps, move to DONE.
  - DONE: at the edge HI/LO are written, the instruction retires into EX/MEM and the FSM returns to IDLE.
- **HI/LO results:**
  - multu: HI = product[2W-1:W], LO = product[W-1:0].
  - divu: HI = remainder, LO = quotient.
  - divu by zero: HI = dividend, LO = all ones. It takes the same cycle count as a normal divide.
- **Stall:** `Out_Stall` = (IDLE and `In_Valid` and MDU op and not `In_Flush`) or BUSY. It is 0 in DONE and 0 while `Rst_n` is low.
- **EX/MEM register:**
  - On each edge with `Out_Stall` = 0, capture the stage outputs, with `Out_Valid` <= `In_Valid` and not `In_Flush`.
  - On an edge with `Out_Stall` = 1, load a bubble: `Out_Valid` = 0, both control outputs = 0. `Out_Result`, `Out_Data` and `Out_Rd` hold their values.
  - Any edge with `Out_Valid` = 0 also forces the control outputs to 0.
- **Retiring MDU instruction:** `Out_Result` = LO value being written, control outputs passed through.
- **Flush:**
  - While BUSY or DONE, aborts to IDLE at the next edge, leaves HI/LO unchanged and loads a bubble.
  - In IDLE, prevents the MDU from starting.

## Timing
- **Reset:** every output = 0, HI = LO = 0, FSM = IDLE, counter = 0. Reset overrides flush and an MDU in progress.
- **ALU ops:** latency 1; result at `Out_Result` after the capturing edge.
- **MDU sequence** (cycle 0 = op present in IDLE):
  - `Out_Stall` is high in cycles 0 through WIDTH, i.e. WIDTH+1 cycles.
  - Cycle WIDTH+1 is DONE with stall low; the instruction appears on the outputs after that edge.
- **Back-to-back:** an mfhi/mflo directly after an MDU op reads the freshly written HI/LO, with no extra stall.
- **Upstream contract:** upstream must not change `In_*` while `Out_Stall` = 1. The stage does not check this.

## Test plan
- **Reset:** `Rst_n` = 0 for 2 edges with `In_Valid` = 1 -> all outputs 0, `Out_Stall` = 0. Release, then add A=4, B=8 (ALUOp 10, funct 100000) -> `Out_Result` = 12, `Out_Valid` = 1 after one edge.
- **Immediate and slt:** ALUSrc = 1, `In_SE` = 0xFFFFFFFF, A = 4, ALUOp 00 -> `Out_Result` = 3. Then slt with A = 0xFFFFFFFE, B = 1 -> `Out_Result` = 1.
- **multu then mfhi/mflo:** multu 0xFFFFFFFF × 0xFFFFFFFF -> stall high for exactly 33 cycles and 33 bubbles at EX/MEM. Then mfhi = 0xFFFFFFFE and mflo = 0x00000001 on consecutive cycles.
- **divu:** 100 / 7 -> LO = 14, HI = 2. Then divu by 0 with A = 55 -> LO = 0xFFFFFFFF, HI = 55, same 33-cycle stall.
- **Flush mid-divide:** `In_Flush` in BUSY cycle 10 -> stall drops the next cycle, HI/LO keep their prior values, `Out_Valid` = 0.
- **Reset mid-multiply:** assert `Rst_n` = 0 during BUSY -> FSM returns to IDLE, HI = LO = 0, all outputs 0 at that edge.

Source files
------------

// File: rtl/ex_stage_mdu.sv
// Execute stage with ALU, iterative unsigned multiply/divide and HI/LO.
// Registers its own EX/MEM outputs and stalls upstream while the MDU runs.
module ex_stage_mdu #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                In_Valid,
    input  logic [WIDTH-1:0]    In_DataA,
    input  logic [WIDTH-1:0]    In_DataB,
    input  logic [WIDTH-1:0]    In_SE,
    input  logic [REG_BITS-1:0] In_Rt,
    input  logic [REG_BITS-1:0] In_Rd,
    input  logic [3:0]          In_EXControl,
    input  logic [1:0]          In_MEMControl,
    input  logic [1:0]          In_WBControl,
    input  logic [5:0]          In_Funct,
    input  logic                In_Flush,
    output logic                Out_Stall,
    output logic                Out_Valid,
    output logic [WIDTH-1:0]    Out_Result,
    output logic [WIDTH-1:0]    Out_Data,
    output logic [REG_BITS-1:0] Out_Rd,
    output logic [1:0]          Out_MEMControl,
    output logic [1:0]          Out_WBControl
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 is_div;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;

    logic [WIDTH-1:0]     op_b;
    logic [1:0]           alu_op;
    logic                 is_mul;
    logic                 is_dvu;
    logic                 start;
    logic                 v_next;
    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     stage_res;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_r;
    logic                 div_ge;
    logic [WIDTH:0]       div_rem;
    logic [2*WIDTH-1:0]   div_next;

    assign op_b   = In_EXControl[0] ? In_SE : In_DataB;
    assign alu_op = In_EXControl[2:1];
    assign is_mul = (alu_op == 2'b10) && (In_Funct == 6'b011001);
    assign is_dvu = (alu_op == 2'b10) && (In_Funct == 6'b011011);
    assign start  = In_Valid && (is_mul || is_dvu) && !In_Flush;
    assign v_next = In_Valid && !In_Flush;

    assign Out_Stall = Rst_n &&
                       (((state == IDLE) && start) || (state == BUSY));

    // Single-cycle ALU result selection
    always_comb begin
        alu_res = '0;
        case (alu_op)
            2'b00: alu_res = In_DataA + op_b;
            2'b01: alu_res = In_DataA - op_b;
            2'b11: alu_res = In_DataA | op_b;
            default: begin
                case (In_Funct)
                    6'b100000: alu_res = In_DataA + op_b;
                    6'b100010: alu_res = In_DataA - op_b;
                    6'b100100: alu_res = In_DataA & op_b;
                    6'b100101: alu_res = In_DataA | op_b;
                    6'b101010: alu_res = {{(WIDTH-1){1'b0}},
                        ($signed(In_DataA) < $signed(op_b))};
                    6'b010000: alu_res = hi;
                    6'b010010: alu_res = lo;
                    default:   alu_res = '0;
                endcase
            end
        endcase
    end

    // One MDU iteration: shift-add multiply or restoring divide step
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = (div_r >= {1'b0, opnd});
        div_rem  = div_ge ? (div_r - {1'b0, opnd}) : div_r;
        div_next = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    end

    // In DONE the accumulator low half is the LO value being retired
    assign stage_res = (state == DONE) ? acc[WIDTH-1:0] : alu_res;

    // MDU sequencer and HI/LO update
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        acc    <= {{WIDTH{1'b0}},
                                   (is_mul ? op_b : In_DataA)};
                        opnd   <= is_mul ? In_DataA : op_b;
                        is_div <= is_dvu;
                    end
                end
                BUSY: begin
                    if (In_Flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!In_Flush) begin
                        hi <= acc[2*WIDTH-1:WIDTH];
                        lo <= acc[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register; stalls load a bubble
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Out_Valid      <= 1'b0;
            Out_Result     <= '0;
            Out_Data       <= '0;
            Out_Rd         <= '0;
            Out_MEMControl <= '0;
            Out_WBControl  <= '0;
        end else if (Out_Stall) begin
            Out_Valid      <= 1'b0;
            Out_MEMControl <= '0;
            Out_WBControl  <= '0;
        end else begin
            Out_Valid      <= v_next;
            Out_Result     <= stage_res;
            Out_Data       <= In_DataB;
            Out_Rd         <= In_EXControl[3] ? In_Rd : In_Rt;
            Out_MEMControl <= v_next ? In_MEMControl : 2'b00;
            Out_WBControl  <= v_next ? In_WBControl : 2'b00;
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Bench for ex_stage_mdu: directed scenarios plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_ex_stage_mdu;

    localparam int W = 32;
    localparam int RB = 5;

    logic          Clk;
    logic          Rst_n;
    logic          In_Valid;
    logic [W-1:0]  In_DataA;
    logic [W-1:0]  In_DataB;
    logic [W-1:0]  In_SE;
    logic [RB-1:0] In_Rt;
    logic [RB-1:0] In_Rd;
    logic [3:0]    In_EXControl;
    logic [1:0]    In_MEMControl;
    logic [1:0]    In_WBControl;
    logic [5:0]    In_Funct;
    logic          In_Flush;
    logic          Out_Stall;
    logic          Out_Valid;
    logic [W-1:0]  Out_Result;
    logic [W-1:0]  Out_Data;
    logic [RB-1:0] Out_Rd;
    logic [1:0]    Out_MEMControl;
    logic [1:0]    Out_WBControl;

    ex_stage_mdu #(.WIDTH(W), .REG_BITS(RB)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid),
        .In_DataA(In_DataA), .In_DataB(In_DataB), .In_SE(In_SE),
        .In_Rt(In_Rt), .In_Rd(In_Rd), .In_EXControl(In_EXControl),
        .In_MEMControl(In_MEMControl), .In_WBControl(In_WBControl),
        .In_Funct(In_Funct), .In_Flush(In_Flush), .Out_Stall(Out_Stall),
        .Out_Valid(Out_Valid), .Out_Result(Out_Result),
        .Out_Data(Out_Data), .Out_Rd(Out_Rd),
        .Out_MEMControl(Out_MEMControl), .Out_WBControl(Out_WBControl)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]  m_hi = '0, m_lo = '0;
    logic [W-1:0]  ma, mb;
    bit            mdiv;
    int            k = 0;
    logic          e_valid = 0;
    logic [W-1:0]  e_result = '0, e_data = '0;
    logic [RB-1:0] e_rd = '0;
    logic [1:0]    e_mem = '0, e_wb = '0;

    function automatic logic [W-1:0] opb_f();
        return In_EXControl[0] ? In_SE : In_DataB;
    endfunction

    function automatic bit is_mdu_f();
        return In_EXControl[2:1] == 2'b10 &&
               (In_Funct == 6'b011001 || In_Funct == 6'b011011);
    endfunction

    function automatic bit exp_stall_f();
        if (!Rst_n) return 0;
        if (k == 0) return In_Valid && is_mdu_f() && !In_Flush;
        return k >= 1 && k <= W;
    endfunction

    function automatic logic [W-1:0] alu_ref();
        logic [W-1:0] a, b;
        a = In_DataA;
        b = opb_f();
        case (In_EXControl[2:1])
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return a | b;
            default: case (In_Funct)
                6'b100000: return a + b;
                6'b100010: return a - b;
                6'b100100: return a & b;
                6'b100101: return a | b;
                6'b101010: return ($signed(a) < $signed(b)) ? 1 : 0;
                6'b010000: return m_hi;
                6'b010010: return m_lo;
                default:   return '0;
            endcase
        endcase
    endfunction

    always @(posedge Clk) begin
        logic [63:0] prod;
        if (!Rst_n) begin
            k = 0; m_hi = '0; m_lo = '0;
            e_valid = 0; e_result = '0; e_data = '0;
            e_rd = '0; e_mem = '0; e_wb = '0;
        end else if (exp_stall_f()) begin
            e_valid = 0; e_mem = '0; e_wb = '0;
            if (k == 0) begin
                k = 1; ma = In_DataA; mb = opb_f();
                mdiv = (In_Funct == 6'b011011);
            end else if (In_Flush) k = 0;
            else k++;
        end else begin
            e_valid  = In_Valid && !In_Flush;
            e_data   = In_DataB;
            e_rd     = In_EXControl[3] ? In_Rd : In_Rt;
            e_mem    = e_valid ? In_MEMControl : 2'b00;
            e_wb     = e_valid ? In_WBControl : 2'b00;
            e_result = alu_ref();
            if (k == W + 1) begin
                if (!In_Flush) begin
                    if (mdiv) begin
                        m_hi = (mb == 0) ? ma : ma % mb;
                        m_lo = (mb == 0) ? '1 : ma / mb;
                    end else begin
                        prod = {32'b0, ma} * {32'b0, mb};
                        m_hi = prod[63:32];
                        m_lo = prod[31:0];
                    end
                    e_result = m_lo;
                end
                k = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("stall", Out_Stall, exp_stall_f());
            chk("valid", Out_Valid, e_valid);
            chk("memctl", Out_MEMControl, e_mem);
            chk("wbctl", Out_WBControl, e_wb);
            if (e_valid) begin
                chk("result", Out_Result, e_result);
                chk("data", Out_Data, e_data);
                chk("rd", Out_Rd, e_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] ex, input logic [5:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] se);
        In_Valid = 1; In_Flush = 0;
        In_EXControl = ex; In_Funct = fn;
        In_DataA = a; In_DataB = b; In_SE = se;
        In_Rd = RB'($urandom); In_Rt = RB'($urandom);
        In_MEMControl = 2'($urandom); In_WBControl = 2'($urandom);
        #1;
    endtask

    task automatic run_mdu(output int st, output int bub);
        st = 0; bub = 0;
        while (Out_Stall && st < 100) begin
            tick();
            st++;
            if (!Out_Valid) bub++;
        end
        tick();
    endtask

    task automatic rand_op();
        logic [5:0] fns [8];
        int r;
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b101010, 6'b010000, 6'b010010, 6'b000111};
        r = $urandom_range(0, 15);
        if (r < 2) begin
            set_op(4'b1100, (r == 0) ? 6'b011001 : 6'b011011,
                   $urandom, ($urandom_range(0, 3) == 0) ? 0 : $urandom,
                   $urandom);
        end else begin
            set_op(4'($urandom), fns[$urandom_range(0, 7)],
                   $urandom, $urandom, $urandom);
        end
        In_Valid = ($urandom_range(0, 7) != 0);
        In_Flush = ($urandom_range(0, 9) == 0);
        #1;
    endtask

    localparam logic [3:0] RTYPE = 4'b1100;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    initial begin
        int st, bub;
        bit was;
        Rst_n = 0;
        set_op(RTYPE, 6'b100000, 32'd1, 32'd2, 32'd0);
        tick();
        chk_en = 1;
        tick();
        chk("rst_valid", Out_Valid, 0);
        chk("rst_result", Out_Result, 0);
        chk("rst_stall", Out_Stall, 0);
        chk("rst_ctl", {Out_MEMControl, Out_WBControl, Out_Rd}, 0);

        Rst_n = 1;
        set_op(RTYPE, 6'b100000, 32'd4, 32'd8, 32'd0);
        tick();
        chk("add_res", Out_Result, 32'd12);
        chk("add_valid", Out_Valid, 1);

        set_op(4'b0001, 6'b000000, 32'd4, 32'd99, 32'hFFFF_FFFF);
        tick();
        chk("imm_res", Out_Result, 32'd3);
        set_op(RTYPE, 6'b101010, 32'hFFFF_FFFE, 32'd1, 32'd0);
        tick();
        chk("slt_res", Out_Result, 32'd1);

        set_op(RTYPE, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_mdu(st, bub);
        chk("mul_stall_cyc", st, 33);
        chk("mul_bubbles", bub, 33);
        chk("mul_lo_out", Out_Result, 32'h1);
        set_op(RTYPE, F_MFHI, 0, 0, 0);
        tick();
        chk("mfhi_mul", Out_Result, 32'hFFFF_FFFE);
        set_op(RTYPE, F_MFLO, 0, 0, 0);
        tick();
        chk("mflo_mul", Out_Result, 32'h1);

        set_op(RTYPE, F_DIVU, 32'd100, 32'd7, 0);
        run_mdu(st, bub);
        chk("div_lo", Out_Result, 32'd14);
        set_op(RTYPE, F_MFHI, 0, 0, 0);
        tick();
        chk("div_hi", Out_Result, 32'd2);

        set_op(RTYPE, F_DIVU, 32'd55, 32'd0, 0);
        run_mdu(st, bub);
        chk("div0_stall_cyc", st, 33);
        chk("div0_lo", Out_Result, 32'hFFFF_FFFF);
        set_op(RTYPE, F_MFHI, 0, 0, 0);
        tick();
        chk("div0_hi", Out_Result, 32'd55);

        set_op(RTYPE, F_DIVU, 32'd1000, 32'd3, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("busy_stall", Out_Stall, 1);
        In_Flush = 1;
        tick();
        In_Flush = 0; In_Valid = 0;
        #1;
        chk("flush_valid", Out_Valid, 0);
        chk("flush_stall", Out_Stall, 0);
        set_op(RTYPE, F_MFHI, 0, 0, 0);
        tick();
        chk("flush_hi", Out_Result, 32'd55);
        set_op(RTYPE, F_MFLO, 0, 0, 0);
        tick();
        chk("flush_lo", Out_Result, 32'hFFFF_FFFF);

        set_op(RTYPE, F_MULTU, 32'd12345, 32'd678, 0);
        for (int i = 0; i < 6; i++) tick();
        Rst_n = 0;
        tick();
        chk("rstm_valid", Out_Valid, 0);
        chk("rstm_result", Out_Result, 0);
        chk("rstm_stall", Out_Stall, 0);
        Rst_n = 1; In_Valid = 0;
        #1;
        chk("rstm_idle", Out_Stall, 0);
        set_op(RTYPE, F_MFHI, 0, 0, 0);
        tick();
        chk("rstm_hi", Out_Result, 0);
        set_op(RTYPE, F_MFLO, 0, 0, 0);
        tick();
        chk("rstm_lo", Out_Result, 0);

        was = 0;
        rand_op();
        for (int i = 0; i < 600; i++) begin
            if (Out_Stall) begin
                tick();
                was = 1;
            end else if (was) begin
                In_Flush = ($urandom_range(0, 5) == 0);
                tick();
                was = 0;
                rand_op();
            end else begin
                tick();
                rand_op();
            end
        end
        In_Valid = 0; In_Flush = 0;
        tick();
        tick();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
